// File: rtl/multiplier_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    HOLD
  } mult_state_t;

  // Step counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/add_sub_nbit.sv
// Combinational (WIDTH+1)-bit adder/subtractor for one multiply step.
module add_sub_nbit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_signed,
  output logic [WIDTH:0]   o_sum
);

  logic [WIDTH:0] w_b_ext;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    w_b_ext = {(i_signed & i_b[WIDTH-1]), i_b};
    o_sum   = i_sub ? (i_a - w_b_ext) : (i_a + w_b_ext);
  end

endmodule

// File: rtl/multiplier_nbit.sv
// Sequential shift-add multiplier: S (snapshotted at Run) times B, product in A:B.
module multiplier_nbit
  import multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ClearA_LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] S,
  input  logic             SignedMode,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = cnt_width(WIDTH);

  mult_state_t      r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sm;
  logic             r_x;
  logic             r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_last;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sum;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // The sign bit of the multiplier carries negative weight, so the final step subtracts.
  add_sub_nbit #(.WIDTH(WIDTH)) u_add_sub (
    .i_a      ({r_x, r_a}),
    .i_b      (r_sm),
    .i_sub    (r_mode & w_last),
    .i_signed (r_mode),
    .o_sum    (w_add)
  );

  assign w_sum = r_b[0] ? w_add : {r_x, r_a};

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sm    <= '0;
      r_x     <= 1'b0;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!Run) begin
            r_sm    <= S;
            r_mode  <= SignedMode;
            r_a     <= '0;
            r_x     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= COMPUTE;
          end else if (!ClearA_LoadB) begin
            r_a <= '0;
            r_x <= 1'b0;
            r_b <= S;
          end
        end
        COMPUTE: begin
          r_x   <= r_mode ? w_sum[WIDTH] : 1'b0;
          r_a   <= {w_sum[WIDTH], w_sum[WIDTH:1]};
          r_b   <= {w_sum[0], r_b[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          // Wait for button release so one press yields exactly one multiply.
          if (Run) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Aval = r_a;
  assign Bval = r_b;
  assign X    = r_x;
  assign Busy = r_busy;
  assign Done = r_done;

endmodule

// File: tb/tb_multiplier_nbit.sv
// Directed-vector bench for multiplier_nbit at WIDTH=8 and WIDTH=16.
module tb_multiplier_nbit;

  logic        clk;
  logic        rst_n;

  logic        cl8, run8, sm8;
  logic [7:0]  s8, a8, b8;
  logic        x8, busy8, done8;

  logic        cl16, run16, sm16;
  logic [15:0] s16, a16, b16;
  logic        x16, busy16, done16;

  int checks;
  int failures;

  multiplier_nbit #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Reset(rst_n), .ClearA_LoadB(cl8), .Run(run8), .S(s8),
    .SignedMode(sm8), .Aval(a8), .Bval(b8), .X(x8), .Busy(busy8), .Done(done8)
  );

  multiplier_nbit #(.WIDTH(16)) u_dut16 (
    .Clk(clk), .Reset(rst_n), .ClearA_LoadB(cl16), .Run(run16), .S(s16),
    .SignedMode(sm16), .Aval(a16), .Bval(b16), .X(x16), .Busy(busy16), .Done(done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One 8-bit multiply; Run stays low for hold_cycles edges after the start edge.
  task automatic mult8(input logic [7:0] bv, input logic [7:0] sv, input logic sgn,
                       input logic load, input int hold_cycles, input int glitch_at,
                       output logic [7:0] ra, output logic [7:0] rb,
                       output int dcount, output int dedge,
                       output logic busy_k, output logic busy_end);
    @(negedge clk);
    if (load) begin
      cl8 = 1'b0; s8 = bv;
      @(negedge clk);
      cl8 = 1'b1;
    end
    s8 = sv; sm8 = sgn; run8 = 1'b0;
    @(posedge clk);
    #1 busy_k = busy8;
    dcount = 0; dedge = -1;
    for (int i = 1; i <= 8 + hold_cycles + 3; i++) begin
      @(posedge clk);
      #1;
      if (done8) begin dcount++; dedge = i; end
      if (i >= hold_cycles) run8 = 1'b1;
      if (glitch_at > 0 && i == glitch_at) begin cl8 = 1'b0; s8 = 8'h55; sm8 = ~sgn; end
      if (glitch_at > 0 && i == glitch_at + 1) cl8 = 1'b1;
    end
    ra = a8; rb = b8; busy_end = busy8;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({a8, b8, x8, busy8, done8} !== 19'd0) begin
      failures++;
      $display("FAIL reset_state8 got=%h exp=0", {a8, b8, x8, busy8, done8});
    end
    checks++;
    if ({a16, b16, x16, busy16, done16} !== 35'd0) begin
      failures++;
      $display("FAIL reset_state16 got=%h exp=0", {a16, b16, x16, busy16, done16});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_signed;
    logic [7:0] ra, rb; int dc, de; logic bk, be;
    mult8(8'hC5, 8'h07, 1'b1, 1'b1, 0, 0, ra, rb, dc, de, bk, be);
    checks++;
    if ({ra, rb} !== 16'hFE63) begin failures++; $display("FAIL signed_c5x07 got=%h exp=fe63", {ra, rb}); end
    checks++;
    if (dc !== 1 || de !== 8) begin failures++; $display("FAIL signed_done_timing count=%0d edge=%0d exp count=1 edge=8", dc, de); end
    checks++;
    if (bk !== 1'b1 || be !== 1'b0) begin failures++; $display("FAIL signed_busy start=%b end=%b exp 1/0", bk, be); end
    checks++;
    if (x8 !== 1'b1) begin failures++; $display("FAIL signed_x got=%b exp=1", x8); end
  endtask

  task automatic test_swapped_and_rerun;
    logic [7:0] ra, rb; int dc, de; logic bk, be;
    mult8(8'h07, 8'hC5, 1'b1, 1'b1, 0, 0, ra, rb, dc, de, bk, be);
    checks++;
    if ({ra, rb} !== 16'hFE63) begin failures++; $display("FAIL swapped_07xc5 got=%h exp=fe63", {ra, rb}); end
    mult8(8'h00, 8'h02, 1'b1, 1'b0, 0, 0, ra, rb, dc, de, bk, be);
    checks++;
    if ({ra, rb} !== 16'h00C6) begin failures++; $display("FAIL rerun_63x02 got=%h exp=00c6", {ra, rb}); end
  endtask

  task automatic test_unsigned;
    logic [7:0] ra, rb; int dc, de; logic bk, be;
    mult8(8'hC5, 8'h07, 1'b0, 1'b1, 0, 0, ra, rb, dc, de, bk, be);
    checks++;
    if ({ra, rb} !== 16'h0563) begin failures++; $display("FAIL unsigned_c5x07 got=%h exp=0563", {ra, rb}); end
    mult8(8'hFF, 8'hFF, 1'b0, 1'b1, 0, 0, ra, rb, dc, de, bk, be);
    checks++;
    if ({ra, rb} !== 16'hFE01) begin failures++; $display("FAIL unsigned_ffxff got=%h exp=fe01", {ra, rb}); end
    checks++;
    if (x8 !== 1'b0) begin failures++; $display("FAIL unsigned_x got=%b exp=0", x8); end
  endtask

  task automatic test_min_and_hold;
    logic [7:0] ra, rb; int dc, de; logic bk, be;
    mult8(8'h80, 8'h80, 1'b1, 1'b1, 30, 0, ra, rb, dc, de, bk, be);
    checks++;
    if ({ra, rb} !== 16'h4000) begin failures++; $display("FAIL signed_80x80 got=%h exp=4000", {ra, rb}); end
    checks++;
    if (dc !== 1) begin failures++; $display("FAIL hold_one_done got=%0d exp=1", dc); end
    checks++;
    if (be !== 1'b0) begin failures++; $display("FAIL hold_busy_low got=%b exp=0", be); end
  endtask

  task automatic test_reset_abort;
    logic [7:0] ra, rb; int dc, de; logic bk, be;
    @(negedge clk);
    cl8 = 1'b0; s8 = 8'hC5;
    @(negedge clk);
    cl8 = 1'b1; s8 = 8'h07; sm8 = 1'b1; run8 = 1'b0;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0; run8 = 1'b1;
    #1;
    checks++;
    if ({a8, b8, x8, busy8, done8} !== 19'd0) begin
      failures++;
      $display("FAIL abort_outputs got=%h exp=0", {a8, b8, x8, busy8, done8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy8 !== 1'b0) begin failures++; $display("FAIL abort_idle busy=%b exp=0", busy8); end
    mult8(8'hC5, 8'h07, 1'b1, 1'b1, 0, 0, ra, rb, dc, de, bk, be);
    checks++;
    if ({ra, rb} !== 16'hFE63) begin failures++; $display("FAIL after_abort got=%h exp=fe63", {ra, rb}); end
  endtask

  task automatic test_load_during_compute;
    logic [7:0] ra, rb; int dc, de; logic bk, be;
    mult8(8'hC5, 8'h07, 1'b0, 1'b1, 0, 3, ra, rb, dc, de, bk, be);
    checks++;
    if ({ra, rb} !== 16'h0563) begin failures++; $display("FAIL load_ignored got=%h exp=0563", {ra, rb}); end
  endtask

  task automatic test_width16;
    int dc, de;
    @(negedge clk);
    cl16 = 1'b0; s16 = 16'hFFFF;
    @(negedge clk);
    cl16 = 1'b1; sm16 = 1'b1; run16 = 1'b0;
    @(posedge clk);
    dc = 0; de = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done16) begin dc++; de = i; end
      run16 = 1'b1;
    end
    checks++;
    if ({a16, b16} !== 32'h0000_0001) begin failures++; $display("FAIL w16_ffffxffff got=%h exp=00000001", {a16, b16}); end
    checks++;
    if (dc !== 1 || de !== 16) begin failures++; $display("FAIL w16_done_timing count=%0d edge=%0d exp count=1 edge=16", dc, de); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    cl8 = 1'b1; run8 = 1'b1; sm8 = 1'b0; s8 = '0;
    cl16 = 1'b1; run16 = 1'b1; sm16 = 1'b0; s16 = '0;
    test_reset();
    test_signed();
    test_swapped_and_rerun();
    test_unsigned();
    test_min_and_hold();
    test_reset_abort();
    test_load_during_compute();
    test_width16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
